// File: rtl/booth_mul_arbiter.sv
// booth_mul_arbiter
// Round-robin arbiter/sequencer sharing one 7x7 signed Booth multiplier among
// NREQ requesters. A winner's operands are latched and the multiplier gets a
// one-cycle start. The product goes back to the winner with a one-cycle done.
// Optional feature macro: BOOTH_ARB_TIMEOUT_EN. When defined, a WAIT that lasts
// TIMEOUT cycles without mul_valid aborts with done+err and a zero result.
// When it is not defined, err is tied low and WAIT holds until mul_valid.
module booth_mul_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [7*NREQ-1:0]      a_in,
  input  logic [7*NREQ-1:0]      b_in,
  output logic [NREQ-1:0]        ack,
  output logic [NREQ-1:0]        done,
  output logic signed [15:0]     result,
  output logic                   err,
  output logic                   busy,
  output logic                   mul_start,
  output logic signed [6:0]      mul_a,
  output logic signed [6:0]      mul_b,
  input  logic signed [15:0]     mul_y,
  input  logic                   mul_valid
);

  localparam int PW = $clog2(NREQ);
  localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_param_check
    $error("booth_mul_arbiter: NREQ must be 2..8 and TIMEOUT at least 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   owner;
  logic [PW-1:0]   grant_idx;
  logic [PW-1:0]   next_ptr;
  logic [PW-1:0]   cand;
  logic [PW:0]     sum;
  logic            grant_found;
  logic            grant;
  logic            complete;
  logic            timeout_hit;
  logic [NREQ-1:0] eligible;

  // Per-requester operand slices, unpacked for direct indexing by the winner.
  logic signed [6:0] a_arr [NREQ];
  logic signed [6:0] b_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_slice
    assign a_arr[i] = a_in[7*i +: 7];
    assign b_arr[i] = b_in[7*i +: 7];
  end

  // The owner's request is masked during its own done cycle, so it can only
  // be granted again if it re-requests on a later cycle.
  assign eligible = req & ~done;
  assign grant    = (state == IDLE) && grant_found;
  assign complete = (state == WAIT) && mul_valid;
  assign busy     = (state != IDLE);
  assign next_ptr = (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;

  // Round-robin search: the first eligible requester at or after ptr wins.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    grant_found = 1'b0;
    grant_idx   = '0;
    sum         = '0;
    cand        = '0;
    // The loop runs downward so the smallest offset from ptr is written last.
    for (int k = NREQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
      cand = sum[PW-1:0];
      if (eligible[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples values from before the edge, whatever order the blocks run in.
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // Next-state logic: one ISSUE cycle, then WAIT until completion or abort.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (grant_found) state_n = ISSUE;
      ISSUE:   state_n = WAIT;
      WAIT:    if (complete || timeout_hit) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Grant, operand capture, and result return. ack, mul_start and done are
  // cleared every cycle, so each one is a single-cycle pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr       <= '0;
      owner     <= '0;
      ack       <= '0;
      done      <= '0;
      mul_start <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      result    <= '0;
    end else begin
      ack       <= '0;
      done      <= '0;
      mul_start <= 1'b0;
      if (grant) begin
        owner     <= grant_idx;
        ptr       <= next_ptr;
        ack       <= ONE << grant_idx;
        mul_start <= 1'b1;
        mul_a     <= a_arr[grant_idx];
        mul_b     <= b_arr[grant_idx];
      end
      if (complete) begin
        result <= mul_y;
        done   <= ONE << owner;
      end else if (timeout_hit) begin
        result <= '0;
        done   <= ONE << owner;
      end
    end
  end

`ifdef BOOTH_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wait_cnt;

  // The counter is zero on WAIT entry. It aborts at the end of the TIMEOUT-th
  // WAIT cycle unless mul_valid arrives on that edge.
  assign timeout_hit = (state == WAIT) && !mul_valid &&
                       (wait_cnt == CW'(TIMEOUT - 1));

  // WAIT-cycle counter, held at zero outside WAIT.
  always_ff @(posedge clk) begin
    if (!rst)                wait_cnt <= '0;
    else if (state != WAIT)  wait_cnt <= '0;
    else if (!mul_valid)     wait_cnt <= wait_cnt + 1'b1;
  end

  // err qualifies done: high for an abort, low for a normal completion.
  always_ff @(posedge clk) begin
    if (!rst)             err <= 1'b0;
    else if (complete)    err <= 1'b0;
    else if (timeout_hit) err <= 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Self-checking bench for booth_mul_arbiter (NREQ=4). Each issued request
// pushes its expected grant and product into scoreboard queues. A monitor on
// the falling edge pops and compares whenever ack or done is presented.
module tb_booth_mul_arbiter;

  localparam int N = 4;

  typedef struct {
    int                 idx;
    logic signed [15:0] res;
    logic               e;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [N-1:0]          req = '0;
  logic [7*N-1:0]        a_in = '0;
  logic [7*N-1:0]        b_in = '0;
  logic [N-1:0]          ack;
  logic [N-1:0]          done;
  logic signed [15:0]    result;
  logic                  err;
  logic                  busy;
  logic                  mul_start;
  logic signed [6:0]     mul_a;
  logic signed [6:0]     mul_b;
  logic signed [15:0]    mul_y = '0;
  logic                  mul_valid = 1'b0;

  int   errors = 0;
  int   checks = 0;
  int   exp_ack [$];
  exp_t exp_done [$];

  // Multiplier model controls.
  logic               mul_en = 1'b1;
  logic               inject = 1'b0;
  int                 mdl_cnt = 0;
  logic signed [15:0] ea, eb, prod;

  booth_mul_arbiter #(.NREQ(N), .TIMEOUT(15)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .a_in      (a_in),
    .b_in      (b_in),
    .ack       (ack),
    .done      (done),
    .result    (result),
    .err       (err),
    .busy      (busy),
    .mul_start (mul_start),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_y     (mul_y),
    .mul_valid (mul_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_op(input int i, input logic signed [6:0] a, input logic signed [6:0] b);
    a_in[7*i +: 7] = a;
    b_in[7*i +: 7] = b;
  endtask

  task automatic expect_txn(input int i, input logic signed [15:0] r, input logic e);
    exp_t t;
    t.idx = i;
    t.res = r;
    t.e   = e;
    exp_ack.push_back(i);
    exp_done.push_back(t);
  endtask

  // Drop each requester's req on its ack; return once everything is idle.
  task automatic serve(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      for (int i = 0; i < N; i++) if (ack[i]) req[i] = 1'b0;
      n++;
    end while ((req != '0 || busy || done != '0) && n < budget);
    if (req != '0 || busy || done != '0) begin
      checks++;
      errors++;
      $display("FAIL serve_budget: still busy after %0d cycles (req=%b busy=%b)", n, req, busy);
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Multiplier model: fixed 3-cycle latency, plus a one-shot stray valid.
  always @(negedge clk) begin : mul_model
    mul_valid = 1'b0;
    if (inject) begin
      mul_valid = 1'b1;
      mul_y     = 16'sd77;
      inject    = 1'b0;
    end
    if (mdl_cnt > 0) begin
      mdl_cnt--;
      if (mdl_cnt == 0) begin
        mul_valid = 1'b1;
        mul_y     = prod;
      end
    end
    if (mul_start && mul_en) begin
      ea      = {{9{mul_a[6]}}, mul_a};
      eb      = {{9{mul_b[6]}}, mul_b};
      prod    = ea * eb;
      mdl_cnt = 3;
    end
  end

  // Scoreboard monitor: compare every presented ack and done against the queues.
  always @(negedge clk) begin : monitor
    int   idx;
    exp_t t;
    if (ack != '0) begin
      if (exp_ack.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got %b expected none", ack);
      end else begin
        idx = exp_ack.pop_front();
        check("ack_grant", 32'(ack), 32'(1 << idx));
        check("start_with_ack", 32'(mul_start), 32'd1);
      end
    end else if (mul_start) begin
      checks++;
      errors++;
      $display("FAIL stray_start: got mul_start=1 expected 0 (no ack)");
    end
    if (done != '0) begin
      if (exp_done.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got %b expected none", done);
      end else begin
        t = exp_done.pop_front();
        check("done_owner", 32'(done), 32'(1 << t.idx));
        check("result", 32'(result), 32'(t.res));
        check("err", 32'(err), 32'(t.e));
      end
      if ((ack & done) != '0) begin
        checks++;
        errors++;
        $display("FAIL ack_done_overlap: got ack=%b done=%b expected disjoint", ack, done);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"},   32'(ack),       32'd0);
    check({tag, "_done"},  32'(done),      32'd0);
    check({tag, "_start"}, 32'(mul_start), 32'd0);
    check({tag, "_err"},   32'(err),       32'd0);
    check({tag, "_busy"},  32'(busy),      32'd0);
    check({tag, "_result"},32'(result),    32'd0);
    check({tag, "_mul_a"}, 32'(mul_a),     32'd0);
    check({tag, "_mul_b"}, 32'(mul_b),     32'd0);
  endtask

  initial begin
    // Reset state.
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;

    // Single request: requester 2, 3 * -5 = -15, with first-cycle latency checks.
    @(negedge clk);
    expect_txn(2, -16'sd15, 1'b0);
    set_op(2, 7'sd3, -7'sd5);
    req[2] = 1'b1;
    @(negedge clk);
    check("single_ack_latency", 32'(ack), 32'b0100);
    check("single_busy", 32'(busy), 32'd1);
    check("single_mul_a", 32'(mul_a), 32'(7'sd3));
    check("single_mul_b", 32'(mul_b), 32'(-7'sd5));
    req[2] = 1'b0;
    serve(100);

    // All four from reset: grant order 0,1,2,3 with back-to-back grants.
    pulse_reset();
    set_op(0, 7'sd2, 7'sd3);    expect_txn(0, 16'sd6, 1'b0);
    set_op(1, -7'sd4, 7'sd5);   expect_txn(1, -16'sd20, 1'b0);
    set_op(2, 7'sd7, -7'sd7);   expect_txn(2, -16'sd49, 1'b0);
    set_op(3, -7'sd8, -7'sd8);  expect_txn(3, 16'sd64, 1'b0);
    req = 4'b1111;
    serve(200);

    // Re-request 0 and 3 together: ptr wrapped to 0, so 0 goes first.
    set_op(0, 7'sd10, 7'sd10);  expect_txn(0, 16'sd100, 1'b0);
    set_op(3, -7'sd1, 7'sd1);   expect_txn(3, -16'sd1, 1'b0);
    req = 4'b1001;
    serve(200);

    // Operand extremes.
    set_op(1, -7'sd64, -7'sd64); expect_txn(1, 16'sd4096, 1'b0);
    req[1] = 1'b1;
    serve(100);
    set_op(2, -7'sd64, 7'sd63);  expect_txn(2, -16'sd4032, 1'b0);
    req[2] = 1'b1;
    serve(100);
    set_op(0, 7'sd0, -7'sd1);    expect_txn(0, 16'sd0, 1'b0);
    req[0] = 1'b1;
    serve(100);

    // Withdrawal: requester 1 drops before grant while 3 holds; only 3 is served.
    set_op(0, 7'sd6, -7'sd2);    expect_txn(0, -16'sd12, 1'b0);
    req[0] = 1'b1;
    @(negedge clk);
    req[0] = 1'b0;
    set_op(1, 7'sd11, 7'sd11);
    set_op(3, -7'sd3, -7'sd3);   expect_txn(3, 16'sd9, 1'b0);
    req[1] = 1'b1;
    req[3] = 1'b1;
    @(negedge clk);
    req[1] = 1'b0;
    serve(100);

    // Multiplier that never answers.
    mul_en = 1'b0;
    set_op(2, 7'sd5, 7'sd5);
`ifdef BOOTH_ARB_TIMEOUT_EN
    expect_txn(2, 16'sd0, 1'b1);
    req[2] = 1'b1;
    @(negedge clk);
    req[2] = 1'b0;
    begin
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (done == '0 && n < 100);
      check("timeout_latency", 32'(n), 32'd16);
    end
    @(negedge clk);
`else
    exp_ack.push_back(2);
    req[2] = 1'b1;
    @(negedge clk);
    req[2] = 1'b0;
    repeat (40) @(negedge clk);
    check("hang_busy", 32'(busy), 32'd1);
    pulse_reset();
`endif

    // Reset mid-WAIT: transaction abandoned, ptr back to 0, late valid ignored.
    set_op(1, 7'sd9, 7'sd9);
    exp_ack.push_back(1);
    req[1] = 1'b1;
    @(negedge clk);
    req[1] = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_reset_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check_all_zero("midwait_reset");
    inject = 1'b1;
    repeat (3) @(negedge clk);
    check("late_valid_done", 32'(done), 32'd0);
    mul_en = 1'b1;
    set_op(1, 7'sd1, 7'sd63);    expect_txn(1, 16'sd63, 1'b0);
    set_op(3, -7'sd64, 7'sd1);   expect_txn(3, -16'sd64, 1'b0);
    req = 4'b1010;
    serve(200);

    repeat (3) @(negedge clk);
    check("ack_queue_empty", 32'(exp_ack.size()), 32'd0);
    check("done_queue_empty", 32'(exp_done.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
